dram_port_arbiter: RTL and testbench
====================================

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (legal 1..3).
REQ-002 SHALL have ports; clock is i_clk and reset is i_rst, one clock; reset is synchronous and active-high:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_noc  in  3  number of active core ports
- i_rd  in  4  per-port read request, bit p = port p
- i_wr  in  4  per-port write request
- i_addr_0..i_addr_3  in  16 each  per-port address
- i_wdata_0..i_wdata_3  in  8 each  per-port write data
- o_rdata_0..o_rdata_3  out  8 each  per-port read data, registered
- o_ack  out  4  per-port one-cycle completion pulse
- o_mem_addr  out  16  memory address
- o_mem_wdata  out  8  memory write data
- o_mem_rden  out  1  memory read strobe
- o_mem_wren  out  1  memory write strobe
- i_mem_q  in  8  memory read data
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_grant  out  2  index of the port currently served

Function
REQ-003 SHALL serve the DRAM side of the core request protocol: four requesters share one single-port memory, with one transaction in flight at a time.
REQ-004 Port p SHALL be eligible only if p < i_noc; i_noc = 0 or i_noc > 4 enables all four ports.
REQ-005 Port p SHALL be requesting when (i_rd[p] | i_wr[p]) is high; if both are high, the transaction SHALL be a write.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-007 IDLE -> ISSUE when at least one eligible, unmasked port is requesting; otherwise the FSM SHALL stay in IDLE.
REQ-008 Round-robin arbitration: search starts at the pointer ptr and proceeds ascending, mod 4; after a grant, ptr SHALL become (granted+1) mod 4.
REQ-009 On the grant edge, the block SHALL latch the port index, rd/wr type, address and write data; later changes to those inputs SHALL be ignored until RESP.
REQ-010 In ISSUE (exactly one cycle), o_mem_addr SHALL equal the latched address and exactly one of o_mem_rden or o_mem_wren SHALL be high.
REQ-011 For writes, o_mem_wdata SHALL equal the latched data in ISSUE.
REQ-012 In all cycles other than ISSUE, both strobes SHALL be 0.
REQ-013 WAIT SHALL last exactly MEM_LAT cycles, counted by a 2-bit counter, for reads and writes alike.
REQ-014 On the edge ending the last WAIT cycle, a read SHALL capture i_mem_q into o_rdata_<granted port>; other o_rdata registers SHALL hold their values.
REQ-015 In RESP (one cycle), o_ack[granted] = 1 and all other o_ack bits = 0; the FSM SHALL then return to IDLE.
REQ-016 Latency SHALL be fixed: grant sampled at cycle N, ISSUE at N+1, o_ack at N+2+MEM_LAT.
REQ-017 Read data SHALL be valid from the ack cycle onward and held until that port's next read completes.
REQ-018 A requester SHALL hold its request until ack and drop it the following cycle.
REQ-019 The block SHALL mask the just-acked port during the IDLE cycle immediately after RESP, so no duplicate grant occurs.
REQ-020 Requests from ineligible ports SHALL never be granted, never be acked, and never stall the block.
REQ-021 i_noc changes SHALL take effect only at the next IDLE arbitration; an in-flight transaction SHALL complete.

Reset
REQ-022 When i_rst = 1 at a clock edge, the following SHALL hold after that edge: FSM = IDLE, ptr = 0, WAIT counter = 0, o_ack = 0, strobes = 0, o_mem_addr = 0, o_mem_wdata = 0, o_busy = 0, o_grant = 0, and all o_rdata = 0.
REQ-023 Reset mid-transaction SHALL abort it: no ack is issued, and no strobe occurs in the cycle after reset; i_rst SHALL override all requests.

Verification
REQ-024 Single read, MEM_LAT=1, i_noc=4: port2 reads 0x0010 with mem[0x0010]=0xA5 -> rden high at N+1 with addr 0x0010, o_ack=4'b0100 at N+3, o_rdata_2=0xA5.
REQ-025 All four ports write simultaneously from reset -> grants in order 0,1,2,3, each writing its own data once; four acks, one per transaction, spaced 4 cycles apart (MEM_LAT=1).
REQ-026 i_noc=2 with all four ports requesting -> only ports 0 and 1 are ever acked; ports 2 and 3 are never strobed.
REQ-027 Port 1 asserts i_rd and i_wr together at address 0x1234 with data 0x3C -> one wren strobe, no rden, mem[0x1234]=0x3C, single ack.
REQ-028 MEM_LAT=3 read -> ack at N+5; port1 changes its address during WAIT -> o_mem_addr and the captured data are unaffected.
REQ-029 i_rst pulsed during WAIT -> no ack, o_busy=0 next cycle, all o_rdata=0; a subsequent request from port 0 completes normally.

Source files
------------

// File: rtl/dram_port_arbiter_if.sv
// Core-port and memory-side bus bundle for dram_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the core requests and models the memory.
interface dram_port_arbiter_if;
  logic [2:0]  i_noc;
  logic [3:0]  i_rd;
  logic [3:0]  i_wr;
  logic [15:0] i_addr_0;
  logic [15:0] i_addr_1;
  logic [15:0] i_addr_2;
  logic [15:0] i_addr_3;
  logic [7:0]  i_wdata_0;
  logic [7:0]  i_wdata_1;
  logic [7:0]  i_wdata_2;
  logic [7:0]  i_wdata_3;
  logic [7:0]  o_rdata_0;
  logic [7:0]  o_rdata_1;
  logic [7:0]  o_rdata_2;
  logic [7:0]  o_rdata_3;
  logic [3:0]  o_ack;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_rden;
  logic        o_mem_wren;
  logic [7:0]  i_mem_q;
  logic        o_busy;
  logic [1:0]  o_grant;

  modport slave (
    input  i_noc, i_rd, i_wr,
    input  i_addr_0, i_addr_1, i_addr_2, i_addr_3,
    input  i_wdata_0, i_wdata_1, i_wdata_2, i_wdata_3,
    input  i_mem_q,
    output o_rdata_0, o_rdata_1, o_rdata_2, o_rdata_3,
    output o_ack, o_mem_addr, o_mem_wdata, o_mem_rden, o_mem_wren,
    output o_busy, o_grant
  );

  modport master (
    output i_noc, i_rd, i_wr,
    output i_addr_0, i_addr_1, i_addr_2, i_addr_3,
    output i_wdata_0, i_wdata_1, i_wdata_2, i_wdata_3,
    output i_mem_q,
    input  o_rdata_0, o_rdata_1, o_rdata_2, o_rdata_3,
    input  o_ack, o_mem_addr, o_mem_wdata, o_mem_rden, o_mem_wren,
    input  o_busy, o_grant
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: four core ports share one single-port memory.
// Round-robin grant, one transaction in flight, fixed latency
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE. All outputs registered.
module dram_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  dram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Counter value in the final WAIT cycle.
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            is_wr_q, is_wr_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            rden_q, rden_d;
  logic            wren_q, wren_d;
  logic [3:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [3:0][7:0] rdata_q, rdata_d;
  logic            mask_en_q, mask_en_d;
  logic [1:0]      mask_port_q, mask_port_d;

  logic [3:0][15:0] addr_s;
  logic [3:0][7:0]  wdata_s;
  logic             all_en_s;
  logic [3:0]       elig_s;
  logic [3:0]       mask_vec_s;
  logic [3:0]       req_s;
  logic             found_s;
  logic [1:0]       pick_s;

  // Gather the per-port address and write-data buses into indexable arrays.
  always_comb begin
    addr_s  = {bus.i_addr_3, bus.i_addr_2, bus.i_addr_1, bus.i_addr_0};
    wdata_s = {bus.i_wdata_3, bus.i_wdata_2, bus.i_wdata_1, bus.i_wdata_0};
  end

  // Eligibility, just-acked masking and round-robin pick starting at ptr.
  always_comb begin
    all_en_s = (bus.i_noc == 3'd0) || (bus.i_noc > 3'd4);
    elig_s   = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      elig_s[p] = all_en_s || (3'(p) < bus.i_noc);
    end
    if (mask_en_q) begin
      mask_vec_s = 4'b0001 << mask_port_q;
    end else begin
      mask_vec_s = 4'b0000;
    end
    req_s   = (bus.i_rd | bus.i_wr) & elig_s & ~mask_vec_s;
    found_s = 1'b0;
    pick_s  = ptr_q;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      if (req_s[ptr_q + 2'(i)]) begin
        found_s = 1'b1;
        pick_s  = ptr_q + 2'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    is_wr_d     = is_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rden_d      = 1'b0;
    wren_d      = 1'b0;
    ack_d       = 4'b0000;
    rdata_d     = rdata_q;
    mask_en_d   = 1'b0;
    mask_port_d = mask_port_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          // Latch the whole request so later input changes are ignored.
          state_d     = ISSUE;
          grant_d     = pick_s;
          ptr_d       = pick_s + 2'd1;
          is_wr_d     = bus.i_wr[pick_s];
          mem_addr_d  = addr_s[pick_s];
          mem_wdata_d = wdata_s[pick_s];
          rden_d      = ~bus.i_wr[pick_s];
          wren_d      = bus.i_wr[pick_s];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 2'd0;
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = 2'd0;
          ack_d   = 4'b0001 << grant_q;
          if (!is_wr_q) begin
            rdata_d[grant_q] = bus.i_mem_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        // Hide the port just served for one arbitration cycle.
        state_d     = IDLE;
        mask_en_d   = 1'b1;
        mask_port_d = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= 2'd0;
      grant_q     <= 2'd0;
      is_wr_q     <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      ack_q       <= 4'b0000;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      mask_en_q   <= 1'b0;
      mask_port_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      is_wr_q     <= is_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rden_q      <= rden_d;
      wren_q      <= wren_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      mask_en_q   <= mask_en_d;
      mask_port_q <= mask_port_d;
    end
  end

  assign bus.o_rdata_0   = rdata_q[0];
  assign bus.o_rdata_1   = rdata_q[1];
  assign bus.o_rdata_2   = rdata_q[2];
  assign bus.o_rdata_3   = rdata_q[3];
  assign bus.o_ack       = ack_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_rden  = rden_q;
  assign bus.o_mem_wren  = wren_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_grant     = grant_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: one instance with MEM_LAT=1 (ifa)
// and one with MEM_LAT=3 (ifb), each with its own behavioural memory.
module tb_dram_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dram_port_arbiter_if ifa ();
  dram_port_arbiter_if ifb ();

  dram_port_arbiter #(.MEM_LAT(1)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  dram_port_arbiter #(.MEM_LAT(3)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten memory locations read back as a fixed function of the address.
  function automatic logic [7:0] seed(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  logic [7:0] mem_a [0:65535];
  bit         vld_a [0:65535];
  logic [7:0] mem_b [0:65535];
  bit         vld_b [0:65535];
  int         wren_a;
  int         rden_a;
  int         ack23_a;

  // Memory model for instance A: write on wren, registered read on rden.
  always @(posedge clk) begin
    if (ifa.o_mem_wren) begin
      mem_a[ifa.o_mem_addr] <= ifa.o_mem_wdata;
      vld_a[ifa.o_mem_addr] <= 1'b1;
      wren_a <= wren_a + 1;
    end
    if (ifa.o_mem_rden) begin
      ifa.i_mem_q <= vld_a[ifa.o_mem_addr] ? mem_a[ifa.o_mem_addr] : seed(ifa.o_mem_addr);
      rden_a <= rden_a + 1;
    end
    if (ifa.o_ack[3:2] != 2'b00) ack23_a <= ack23_a + 1;
  end

  // Memory model for instance B.
  always @(posedge clk) begin
    if (ifb.o_mem_wren) begin
      mem_b[ifb.o_mem_addr] <= ifb.o_mem_wdata;
      vld_b[ifb.o_mem_addr] <= 1'b1;
    end
    if (ifb.o_mem_rden) begin
      ifb.i_mem_q <= vld_b[ifb.o_mem_addr] ? mem_b[ifb.o_mem_addr] : seed(ifb.o_mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port_a(input int p, input logic [15:0] a, input logic [7:0] d);
    case (p)
      0: begin ifa.i_addr_0 = a; ifa.i_wdata_0 = d; end
      1: begin ifa.i_addr_1 = a; ifa.i_wdata_1 = d; end
      2: begin ifa.i_addr_2 = a; ifa.i_wdata_2 = d; end
      default: begin ifa.i_addr_3 = a; ifa.i_wdata_3 = d; end
    endcase
  endtask

  int s_wr;
  int s_rd;
  int s_ak;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.i_noc = 3'd4; ifa.i_rd = 4'b0000; ifa.i_wr = 4'b0000;
    ifb.i_noc = 3'd4; ifb.i_rd = 4'b0000; ifb.i_wr = 4'b0000;
    for (int p = 0; p < 4; p++) set_port_a(p, 16'h0000, 8'h00);
    ifb.i_addr_0 = 16'h0000; ifb.i_addr_1 = 16'h0000; ifb.i_addr_2 = 16'h0000; ifb.i_addr_3 = 16'h0000;
    ifb.i_wdata_0 = 8'h00; ifb.i_wdata_1 = 8'h00; ifb.i_wdata_2 = 8'h00; ifb.i_wdata_3 = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_busy", {15'd0, ifa.o_busy}, 16'h0000);
    chk("rst_ack", {12'd0, ifa.o_ack}, 16'h0000);
    chk("rst_strobes", {14'd0, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0000);
    chk("rst_addr", ifa.o_mem_addr, 16'h0000);
    chk("rst_wdata_grant", {6'd0, ifa.o_mem_wdata, ifa.o_grant}, 16'h0000);
    chk("rst_rdata", {ifa.o_rdata_3, ifa.o_rdata_2} | {ifa.o_rdata_1, ifa.o_rdata_0}, 16'h0000);

    // Single read, port 2, addr 0x0010 -> 0xA5; ack three cycles after grant.
    set_port_a(2, 16'h0010, 8'h00);
    ifa.i_rd = 4'b0100;
    tick();
    chk("rd_issue_strb", {14'd0, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0002);
    chk("rd_issue_addr", ifa.o_mem_addr, 16'h0010);
    chk("rd_issue_grant", {14'd0, ifa.o_grant}, 16'h0002);
    chk("rd_issue_busy", {15'd0, ifa.o_busy}, 16'h0001);
    tick();
    chk("rd_wait_strb", {14'd0, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0000);
    chk("rd_wait_ack", {12'd0, ifa.o_ack}, 16'h0000);
    tick();
    chk("rd_resp_ack", {12'd0, ifa.o_ack}, 16'h0004);
    chk("rd_rdata2", {8'd0, ifa.o_rdata_2}, 16'h00A5);
    tick();
    ifa.i_rd = 4'b0000;
    chk("rd_idle_ack", {12'd0, ifa.o_ack}, 16'h0000);
    chk("rd_idle_busy", {15'd0, ifa.o_busy}, 16'h0000);

    // Four simultaneous writes from reset: grants 0,1,2,3, acks every 4 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_wr = wren_a;
    for (int p = 0; p < 4; p++) set_port_a(p, 16'h0100 + 16'(p), 8'h10 + 8'(p));
    ifa.i_wr = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) ifa.i_wr[k-1] = 1'b0;
      chk("wr4_grant", {14'd0, ifa.o_grant}, 16'(k));
      chk("wr4_strb", {14'd0, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0001);
      chk("wr4_addr", ifa.o_mem_addr, 16'h0100 + 16'(k));
      chk("wr4_wdata", {8'd0, ifa.o_mem_wdata}, 16'h0010 + 16'(k));
      tick();
      chk("wr4_wait_ack", {12'd0, ifa.o_ack}, 16'h0000);
      tick();
      chk("wr4_ack", {12'd0, ifa.o_ack}, 16'h0001 << k);
      tick();
      chk("wr4_idle_ack", {12'd0, ifa.o_ack}, 16'h0000);
    end
    // Port 3 still requests during the post-ack idle cycle: it must be masked.
    tick();
    chk("wr4_mask_busy", {15'd0, ifa.o_busy}, 16'h0000);
    ifa.i_wr = 4'b0000;
    tick();
    chk("wr4_count", 16'(wren_a - s_wr), 16'h0004);
    for (int k = 0; k < 4; k++) chk("wr4_mem", {8'd0, mem_a[16'h0100 + 16'(k)]}, 16'h0010 + 16'(k));

    // i_noc = 2 with all four ports reading: only ports 0 and 1 served.
    ifa.i_noc = 3'd2;
    s_rd = rden_a;
    s_ak = ack23_a;
    for (int p = 0; p < 4; p++) set_port_a(p, 16'h0200 + 16'(p), 8'h00);
    ifa.i_rd = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (k > 0) ifa.i_rd[k-1] = 1'b0;
      chk("noc2_grant", {14'd0, ifa.o_grant}, 16'(k));
      chk("noc2_addr", ifa.o_mem_addr, 16'h0200 + 16'(k));
      tick();
      tick();
      chk("noc2_ack", {12'd0, ifa.o_ack}, 16'h0001 << k);
      tick();
    end
    tick();
    ifa.i_rd[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("noc2_idle_busy", {15'd0, ifa.o_busy}, 16'h0000);
    end
    chk("noc2_rden_count", 16'(rden_a - s_rd), 16'h0002);
    chk("noc2_ack23", 16'(ack23_a - s_ak), 16'h0000);
    chk("noc2_rdata0", {8'd0, ifa.o_rdata_0}, {8'd0, seed(16'h0200)});
    chk("noc2_rdata1", {8'd0, ifa.o_rdata_1}, {8'd0, seed(16'h0201)});
    ifa.i_rd = 4'b0000;
    ifa.i_noc = 3'd4;
    tick();

    // Port 1 with rd and wr together: treated as a write.
    s_wr = wren_a;
    s_rd = rden_a;
    set_port_a(1, 16'h1234, 8'h3C);
    ifa.i_rd = 4'b0010;
    ifa.i_wr = 4'b0010;
    tick();
    chk("rw_strb", {14'd0, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0001);
    chk("rw_addr", ifa.o_mem_addr, 16'h1234);
    chk("rw_wdata", {8'd0, ifa.o_mem_wdata}, 16'h003C);
    tick();
    tick();
    chk("rw_ack", {12'd0, ifa.o_ack}, 16'h0002);
    tick();
    ifa.i_rd = 4'b0000;
    ifa.i_wr = 4'b0000;
    tick();
    tick();
    chk("rw_counts", {8'(wren_a - s_wr), 8'(rden_a - s_rd)}, 16'h0100);
    chk("rw_mem", {8'd0, mem_a[16'h1234]}, 16'h003C);

    // MEM_LAT = 3: ack five cycles after grant, address change in WAIT ignored.
    ifb.i_addr_1 = 16'h0040;
    ifb.i_rd = 4'b0010;
    tick();
    chk("lat3_issue_strb", {14'd0, ifb.o_mem_rden, ifb.o_mem_wren}, 16'h0002);
    chk("lat3_issue_addr", ifb.o_mem_addr, 16'h0040);
    tick();
    ifb.i_addr_1 = 16'h0041;
    chk("lat3_w1_ack", {12'd0, ifb.o_ack}, 16'h0000);
    tick();
    chk("lat3_w2_addr", ifb.o_mem_addr, 16'h0040);
    chk("lat3_w2_ack", {12'd0, ifb.o_ack}, 16'h0000);
    tick();
    chk("lat3_w3_ack_strb", {10'd0, ifb.o_ack, ifb.o_mem_rden, ifb.o_mem_wren}, 16'h0000);
    tick();
    chk("lat3_ack", {12'd0, ifb.o_ack}, 16'h0002);
    chk("lat3_rdata1", {8'd0, ifb.o_rdata_1}, {8'd0, seed(16'h0040)});
    tick();
    ifb.i_rd = 4'b0000;

    // Reset during WAIT aborts the read: no ack, all rdata cleared.
    set_port_a(3, 16'h0300, 8'h00);
    ifa.i_rd = 4'b1000;
    tick();
    chk("abort_issue", {14'd0, ifa.o_grant}, 16'h0003);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.i_rd = 4'b0000;
    chk("abort_busy", {15'd0, ifa.o_busy}, 16'h0000);
    chk("abort_ack", {12'd0, ifa.o_ack}, 16'h0000);
    chk("abort_rdata", {ifa.o_rdata_3, ifa.o_rdata_2} | {ifa.o_rdata_1, ifa.o_rdata_0}, 16'h0000);
    tick();
    chk("abort_after", {10'd0, ifa.o_ack, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0000);
    set_port_a(0, 16'h0010, 8'h00);
    ifa.i_rd = 4'b0001;
    tick();
    chk("post_issue", {12'd0, ifa.o_grant, ifa.o_mem_rden, ifa.o_mem_wren}, 16'h0002);
    tick();
    tick();
    chk("post_ack", {12'd0, ifa.o_ack}, 16'h0001);
    chk("post_rdata0", {8'd0, ifa.o_rdata_0}, 16'h00A5);
    tick();
    ifa.i_rd = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
